// File: rtl/iq_alu_sched_if.sv
// Signal bundle between rename/dispatch, the ALU issue-queue scheduler
// and the two ALU pipes.
interface iq_alu_sched_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned OP_W  = 8,
    parameter int unsigned NWK   = 4
) ();
    logic                 flush;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [TAG_W-1:0]     disp_src1;
    logic [TAG_W-1:0]     disp_src2;
    logic [TAG_W-1:0]     disp_dst;
    logic [OP_W-1:0]      disp_op;
    logic [NWK-1:0]       wk_valid;
    logic [NWK*TAG_W-1:0] wk_tag;
    logic                 iss0_valid;
    logic                 iss1_valid;
    logic [2:0]           iss0_idx;
    logic [2:0]           iss1_idx;
    logic [OP_W-1:0]      iss0_op;
    logic [OP_W-1:0]      iss1_op;
    logic [TAG_W-1:0]     iss0_dst;
    logic [TAG_W-1:0]     iss1_dst;
    logic [1:0]           replay;
    logic [2:0]           count;

    modport master (
        output flush, disp_valid, disp_src1, disp_src2, disp_dst, disp_op,
               wk_valid, wk_tag, replay,
        input  disp_ready, iss0_valid, iss1_valid, iss0_idx, iss1_idx,
               iss0_op, iss1_op, iss0_dst, iss1_dst, count
    );

    modport slave (
        input  flush, disp_valid, disp_src1, disp_src2, disp_dst, disp_op,
               wk_valid, wk_tag, replay,
        output disp_ready, iss0_valid, iss1_valid, iss0_idx, iss1_idx,
               iss0_op, iss1_op, iss0_dst, iss1_dst, count
    );
endinterface

// File: rtl/iq_alu_sched.sv
// Seven-entry ALU issue queue: allocation, operand wakeup, 2-wide
// lowest-index-first select, one-cycle issue hold with replay.
module iq_alu_sched #(
    parameter int unsigned ENTRIES = 7,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned OP_W    = 8,
    parameter int unsigned NWK     = 4
) (
    input logic           clk,
    input logic           rst_n,
    iq_alu_sched_if.slave bus
);
    typedef enum logic [1:0] {E_FREE, E_WAIT, E_ISSUED} ent_state_e;

    ent_state_e         st_q   [ENTRIES];
    ent_state_e         st_d   [ENTRIES];
    logic [TAG_W-1:0]   src1_q [ENTRIES];
    logic [TAG_W-1:0]   src1_d [ENTRIES];
    logic [TAG_W-1:0]   src2_q [ENTRIES];
    logic [TAG_W-1:0]   src2_d [ENTRIES];
    logic [TAG_W-1:0]   dst_q  [ENTRIES];
    logic [TAG_W-1:0]   dst_d  [ENTRIES];
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [OP_W-1:0]    op_d   [ENTRIES];
    logic [ENTRIES-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;

    logic [1:0]            iss_v_q, iss_v_d;
    logic [1:0][2:0]       iss_idx_q, iss_idx_d;
    logic [1:0][OP_W-1:0]  iss_op_q, iss_op_d;
    logic [1:0][TAG_W-1:0] iss_dst_q, iss_dst_d;
    logic [2:0]            count_q, count_d;

    logic [ENTRIES-1:0] free_vec, cand_vec;
    logic               alloc_v;
    logic [2:0]         alloc_idx;
    logic [1:0]         sel_v;
    logic [1:0][2:0]    sel_idx;
    logic               disp_fire;

    // Internal wakeup comes from the issue registers: 1-cycle ALU latency.
    function automatic logic woken(
        input logic [TAG_W-1:0]     tag,
        input logic [NWK-1:0]       wv,
        input logic [NWK*TAG_W-1:0] wt,
        input logic [1:0]           iv,
        input logic [TAG_W-1:0]     id0,
        input logic [TAG_W-1:0]     id1
    );
        logic hit;
        hit = (iv[0] && id0 == tag) || (iv[1] && id1 == tag);
        for (int unsigned k = 0; k < NWK; k++) begin
            if (wv[k] && wt[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        free_vec  = '0;
        cand_vec  = '0;
        alloc_v   = 1'b0;
        alloc_idx = '0;
        sel_v     = '0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            free_vec[i] = (st_q[i] == E_FREE);
            cand_vec[i] = (st_q[i] == E_WAIT) && rdy1_q[i] && rdy2_q[i];
            if (free_vec[i] && !alloc_v) begin
                alloc_v   = 1'b1;
                alloc_idx = 3'(i);
            end
            if (cand_vec[i]) begin
                if (!sel_v[0]) begin
                    sel_v[0]   = 1'b1;
                    sel_idx[0] = 3'(i);
                end else if (!sel_v[1]) begin
                    sel_v[1]   = 1'b1;
                    sel_idx[1] = 3'(i);
                end
            end
        end
    end

    assign disp_fire = bus.disp_valid && alloc_v;

    always_comb begin
        st_d      = st_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        dst_d     = dst_q;
        op_d      = op_q;
        rdy1_d    = rdy1_q;
        rdy2_d    = rdy2_q;
        iss_v_d   = sel_v;
        iss_idx_d = iss_idx_q;
        iss_op_d  = iss_op_q;
        iss_dst_d = iss_dst_q;

        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (st_q[i] != E_FREE) begin
                rdy1_d[i] = rdy1_q[i] | woken(src1_q[i], bus.wk_valid, bus.wk_tag,
                                              iss_v_q, iss_dst_q[0], iss_dst_q[1]);
                rdy2_d[i] = rdy2_q[i] | woken(src2_q[i], bus.wk_valid, bus.wk_tag,
                                              iss_v_q, iss_dst_q[0], iss_dst_q[1]);
            end
        end

        // Retire/replay, select and dispatch always touch distinct entries.
        for (int unsigned p = 0; p < 2; p++) begin
            if (iss_v_q[p]) st_d[iss_idx_q[p]] = bus.replay[p] ? E_WAIT : E_FREE;
            if (sel_v[p]) begin
                st_d[sel_idx[p]] = E_ISSUED;
                iss_idx_d[p]     = sel_idx[p];
                iss_op_d[p]      = op_q[sel_idx[p]];
                iss_dst_d[p]     = dst_q[sel_idx[p]];
            end
        end

        if (disp_fire) begin
            st_d[alloc_idx]   = E_WAIT;
            src1_d[alloc_idx] = bus.disp_src1;
            src2_d[alloc_idx] = bus.disp_src2;
            dst_d[alloc_idx]  = bus.disp_dst;
            op_d[alloc_idx]   = bus.disp_op;
            rdy1_d[alloc_idx] = (bus.disp_src1 == '0) ||
                                woken(bus.disp_src1, bus.wk_valid, bus.wk_tag,
                                      iss_v_q, iss_dst_q[0], iss_dst_q[1]);
            rdy2_d[alloc_idx] = (bus.disp_src2 == '0) ||
                                woken(bus.disp_src2, bus.wk_valid, bus.wk_tag,
                                      iss_v_q, iss_dst_q[0], iss_dst_q[1]);
        end

        if (bus.flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) st_d[i] = E_FREE;
            iss_v_d = '0;
        end

        count_d = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (st_d[i] != E_FREE) count_d = count_d + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                st_q[i]   <= E_FREE;
                src1_q[i] <= '0;
                src2_q[i] <= '0;
                dst_q[i]  <= '0;
                op_q[i]   <= '0;
            end
            rdy1_q    <= '0;
            rdy2_q    <= '0;
            iss_v_q   <= '0;
            iss_idx_q <= '0;
            iss_op_q  <= '0;
            iss_dst_q <= '0;
            count_q   <= '0;
        end else begin
            st_q      <= st_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dst_q     <= dst_d;
            op_q      <= op_d;
            rdy1_q    <= rdy1_d;
            rdy2_q    <= rdy2_d;
            iss_v_q   <= iss_v_d;
            iss_idx_q <= iss_idx_d;
            iss_op_q  <= iss_op_d;
            iss_dst_q <= iss_dst_d;
            count_q   <= count_d;
        end
    end

    assign bus.disp_ready = alloc_v;
    assign bus.iss0_valid = iss_v_q[0];
    assign bus.iss1_valid = iss_v_q[1];
    assign bus.iss0_idx   = iss_idx_q[0];
    assign bus.iss1_idx   = iss_idx_q[1];
    assign bus.iss0_op    = iss_op_q[0];
    assign bus.iss1_op    = iss_op_q[1];
    assign bus.iss0_dst   = iss_dst_q[0];
    assign bus.iss1_dst   = iss_dst_q[1];
    assign bus.count      = count_q;
endmodule
